pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, handshaked pipeline-stage register.
- Generalises the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block with two payload groups:
  - a datapath group, which is held on bubble;
  - a control group, which is forced to zero on bubble or flush.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput under backpressure, and a saturating bubble-cycle performance counter.
- Sits between any two CPU pipeline stages. The hazard unit drives flush; downstream stall drives out_ready.

Parameters:
- DATA_W, 168: width of the datapath payload (operands, PC, register indices, immediate, PC+4).
- CTRL_W, 10: width of the control payload (reg_write, result_src, mem_write, jump, branch, alu_control, alu_src, ...).
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  clock, rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  kill every entry held in this stage.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload.
- in_data  in  DATA_W  datapath payload in.
- in_ctrl  in  CTRL_W  control payload in.
- out_valid  out  1  output payload valid.
- out_ready  in  1  downstream accepts the payload.
- out_data  out  DATA_W  datapath payload out.
- out_ctrl  out  CTRL_W  control payload out; zero whenever out_valid=0.
- bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0.
- bubble_clr  in  1  synchronous clear of bubble_cnt.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low: reset_n is sampled at the rising edge of clk.
- Reset values (reset_n=0 at a clock edge):
  - state=EMPTY;
  - main and skid data/ctrl = 0;
  - out_valid=0, out_data=0, out_ctrl=0;
  - bubble_cnt=0.
  - in_ready is 0 while reset_n=0.
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: a main register drives out_*; a skid register holds data and ctrl.
- State-derived signals:
  - in_ready = reset_n & (state != TWO). This is a registered-state decode with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- States: EMPTY, ONE (main full), TWO (main and skid full).
- Transitions, at the clock edge, with flush=0:
  - EMPTY, in_fire: main <= in → ONE.
  - ONE, in_fire & out_fire: main <= in → ONE.
  - ONE, in_fire & !out_fire: skid <= in → TWO.
  - ONE, !in_fire & out_fire → EMPTY. main ctrl <= 0; main data is held.
  - ONE, neither: hold.
  - TWO, out_fire: main <= skid; skid ctrl <= 0 → ONE.
  - TWO, !out_fire: hold. in_ready=0, so no input is taken.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Sustains 1 transfer per cycle while out_ready=1.
- Flush has priority over everything except reset:
  - state <= EMPTY.
  - main ctrl and skid ctrl <= 0.
  - main data <= in_data (pass-through, matching existing stage behaviour). skid data is held.
  - An input presented in the flush cycle is accepted (in_ready per state) and discarded.
  - The output transfer in that cycle still completes, since out_fire is evaluated on pre-edge values.
- Bubble invariant: out_ctrl must be all-zero whenever out_valid=0, so a bubble never writes the register file or memory.
- Ordering: payloads leave in acceptance order; no duplication or loss except on flush.
- bubble_cnt:
  - Increments by 1 on each edge where out_valid=0 (pre-edge value).
  - Saturates at 2^CNT_W-1.
  - bubble_clr=1 sets it to 0 and wins over increment.
  - flush does not clear it.
- Reset mid-operation: all state is discarded in the same edge and in_ready=0 during reset. The first accept is possible in the cycle after reset_n returns to 1.

Test Plan:
- Streaming: reset, then 8 back-to-back inputs (data=i, ctrl=i+1), out_ready=1 → out_valid rises 1 cycle after the first input; 8 consecutive outputs in order; state never reaches TWO; bubble_cnt=2 (reset-release cycle plus the first empty cycle).
- Backpressure: feed A, B with out_ready=0 → state TWO, in_ready=0, out_data=A held. Raise out_ready → A, then B, in order; in_ready returns to 1 one cycle after the first out_fire.
- Flush in TWO while in_valid=1 (C) → next cycle out_valid=0, out_ctrl=0, out_data=C's data, in_ready=1; A, B, C never appear as valid.
- Bubble counter: CNT_W=3, idle 10 cycles → bubble_cnt saturates at 7. Pulse bubble_clr → 0. Simultaneous clr and bubble → 0.
- Reset mid-flight: state TWO, assert reset_n=0 for 1 cycle → out_valid=0, outputs 0, in_ready=0 during reset, 1 the cycle after. A new input passes through with 1-cycle latency.
- Randomised in_valid/out_ready/flush (1000 cycles) against a queue model → no loss or duplication outside flush; out_ctrl=0 whenever out_valid=0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, 2-entry skid buffer,
// bubble-zeroed control payload and a saturating bubble-cycle counter.
module pipe_stage_elastic #(
    parameter int DATA_W = 168,
    parameter int CTRL_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt,
    input  logic              bubble_clr
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};
    localparam logic [CTRL_W-1:0] ZERO_CTRL = {CTRL_W{1'b0}};
    localparam logic [CNT_W-1:0]  ZERO_CNT  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t              state_r;
    logic                full_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   main_data_r;
    logic [CTRL_W-1:0]   main_ctrl_r;
    logic [DATA_W-1:0]   skid_data_r;
    logic [CTRL_W-1:0]   skid_ctrl_r;
    logic [CNT_W-1:0]    bubble_cnt_r;
    logic                in_fire_s;
    logic                out_fire_s;

    // full_r mirrors state==TWO so in_ready has no path from out_ready
    assign in_ready   = reset_n & ~full_r;
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = out_valid_r & out_ready;

    assign out_valid  = out_valid_r;
    assign out_data   = main_data_r;
    assign out_ctrl   = main_ctrl_r;
    assign bubble_cnt = bubble_cnt_r;

    // Occupancy FSM together with the main/skid payload registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_EMPTY;
            full_r      <= 1'b0;
            out_valid_r <= 1'b0;
            main_data_r <= ZERO_DATA;
            main_ctrl_r <= ZERO_CTRL;
            skid_data_r <= ZERO_DATA;
            skid_ctrl_r <= ZERO_CTRL;
        end else if (flush) begin
            // Data passes through so a flushed stage looks like the legacy register
            state_r     <= ST_EMPTY;
            full_r      <= 1'b0;
            out_valid_r <= 1'b0;
            main_data_r <= in_data;
            main_ctrl_r <= ZERO_CTRL;
            skid_ctrl_r <= ZERO_CTRL;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_data_r <= in_data;
                        main_ctrl_r <= in_ctrl;
                        state_r     <= ST_ONE;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire_s && out_fire_s) begin
                        main_data_r <= in_data;
                        main_ctrl_r <= in_ctrl;
                    end else if (in_fire_s) begin
                        skid_data_r <= in_data;
                        skid_ctrl_r <= in_ctrl;
                        state_r     <= ST_TWO;
                        full_r      <= 1'b1;
                    end else if (out_fire_s) begin
                        main_ctrl_r <= ZERO_CTRL;
                        state_r     <= ST_EMPTY;
                        out_valid_r <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (out_fire_s) begin
                        main_data_r <= skid_data_r;
                        main_ctrl_r <= skid_ctrl_r;
                        skid_ctrl_r <= ZERO_CTRL;
                        state_r     <= ST_ONE;
                        full_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ST_EMPTY;
                    full_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                    main_ctrl_r <= ZERO_CTRL;
                    skid_ctrl_r <= ZERO_CTRL;
                end
            endcase
        end
    end

    // Saturating count of edges that see an empty output; clear beats increment
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_cnt_r <= ZERO_CNT;
        end else if (bubble_clr) begin
            bubble_cnt_r <= ZERO_CNT;
        end else if (!out_valid_r && (bubble_cnt_r != CNT_MAX)) begin
            bubble_cnt_r <= bubble_cnt_r + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed vector table, hand-written corner
// sequences and randomized traffic checked against a queue model.
module tb_pipe_stage_elastic;

    localparam int DATA_W  = 168;
    localparam int CTRL_W  = 10;
    localparam int CNT_W   = 16;
    localparam int CNT_W_C = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n, flush, in_valid, out_ready, bubble_clr;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_ready, out_valid;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              in_ready_c, out_valid_c;
    logic [DATA_W-1:0] out_data_c;
    logic [CTRL_W-1:0] out_ctrl_c;
    logic [CNT_W_C-1:0] bubble_cnt_c;

    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .bubble_cnt(bubble_cnt), .bubble_clr(bubble_clr));

    // Second instance with a narrow counter, driven by the same stimulus
    pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W_C)) dut_c (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c), .out_ctrl(out_ctrl_c),
        .bubble_cnt(bubble_cnt_c), .bubble_clr(bubble_clr));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a capacity-2 FIFO of payloads plus the value shown while empty
    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } item_t;

    item_t             mq[$];
    logic [DATA_W-1:0] m_held = '0;
    int                m_cnt = 0;
    int                m_cnt_c = 0;

    task automatic model_edge();
        item_t it;
        bit    ifire, ofire;
        if (!reset_n) begin
            mq.delete();
            m_held  = '0;
            m_cnt   = 0;
            m_cnt_c = 0;
        end else begin
            ifire = in_valid && (mq.size() < 2);
            ofire = (mq.size() > 0) && out_ready;
            if (bubble_clr) begin
                m_cnt   = 0;
                m_cnt_c = 0;
            end else if (mq.size() == 0) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                if (m_cnt_c < (1 << CNT_W_C) - 1) m_cnt_c++;
            end
            if (flush) begin
                mq.delete();
                m_held = in_data;
            end else begin
                if (ofire) begin
                    m_held = mq[0].d;
                    void'(mq.pop_front());
                end
                if (ifire) begin
                    it.d = in_data;
                    it.c = in_ctrl;
                    mq.push_back(it);
                end
            end
        end
    endtask

    task automatic check_model();
        logic              ev;
        logic [DATA_W-1:0] ed;
        logic [CTRL_W-1:0] ec;
        ev = (mq.size() > 0);
        ed = ev ? mq[0].d : m_held;
        ec = ev ? mq[0].c : '0;
        chk("m.out_valid", DATA_W'(out_valid), DATA_W'(ev));
        chk("m.in_ready", DATA_W'(in_ready), DATA_W'(reset_n && (mq.size() < 2)));
        chk("m.out_data", out_data, ed);
        chk("m.out_ctrl", DATA_W'(out_ctrl), DATA_W'(ec));
        chk("m.bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(m_cnt));
        chk("m.bubble_cnt_c", DATA_W'(bubble_cnt_c), DATA_W'(m_cnt_c));
        chk("m.out_valid_c", DATA_W'(out_valid_c), DATA_W'(ev));
        chk("m.out_ctrl_c", DATA_W'(out_ctrl_c), DATA_W'(ec));
        chk("m.out_data_c", out_data_c, ed);
        chk("m.in_ready_c", DATA_W'(in_ready_c), DATA_W'(reset_n && (mq.size() < 2)));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic rst, input logic iv, input logic ordy, input logic fl,
                         input logic clr, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        reset_n    = rst;
        in_valid   = iv;
        out_ready  = ordy;
        flush      = fl;
        bubble_clr = clr;
        in_data    = d;
        in_ctrl    = c;
    endtask

    typedef struct {
        logic       rst, iv, ordy, fl;
        logic [7:0] d;
        logic [9:0] c;
        logic       ev, eir;
        logic [7:0] ed;
        logic [9:0] ec;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rst, input logic iv, input logic ordy, input logic fl,
                       input logic [7:0] d, input logic [9:0] c,
                       input logic ev, input logic eir, input logic [7:0] ed, input logic [9:0] ec);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d; v.c = c;
        v.ev = ev; v.eir = eir; v.ed = ed; v.ec = ec;
        vt.push_back(v);
    endtask

    initial begin
        logic [191:0] rnd;

        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();

        //   rst   iv    ordy  flush d       c         ev    ir    data    ctrl
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 8'h00, 10'h000);
        add(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'h000, 1'b0, 1'b1, 8'h00, 10'h000);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h01, 10'h002, 1'b1, 1'b1, 8'h01, 10'h002);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 10'h003, 1'b1, 1'b1, 8'h02, 10'h003);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 1'b0, 1'b1, 8'h02, 10'h000);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h0a, 10'h011, 1'b1, 1'b1, 8'h0a, 10'h011);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h0b, 10'h022, 1'b1, 1'b0, 8'h0a, 10'h011);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h0c, 10'h044, 1'b1, 1'b0, 8'h0a, 10'h011);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 1'b1, 1'b1, 8'h0b, 10'h022);
        add(1'b1, 1'b1, 1'b0, 1'b0, 8'h0d, 10'h033, 1'b1, 1'b0, 8'h0b, 10'h022);
        add(1'b1, 1'b1, 1'b0, 1'b1, 8'h0c, 10'h044, 1'b0, 1'b1, 8'h0c, 10'h000);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 1'b0, 1'b1, 8'h0c, 10'h000);
        add(1'b1, 1'b1, 1'b0, 1'b1, 8'h0e, 10'h055, 1'b0, 1'b1, 8'h0e, 10'h000);
        add(1'b1, 1'b1, 1'b1, 1'b0, 8'h0f, 10'h3ff, 1'b1, 1'b1, 8'h0f, 10'h3ff);
        add(1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 10'h007, 1'b0, 1'b1, 8'h05, 10'h000);

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].iv, vt[i].ordy, vt[i].fl, 1'b0, DATA_W'(vt[i].d), vt[i].c);
            step();
            chk($sformatf("vec%0d.out_valid", i), DATA_W'(out_valid), DATA_W'(vt[i].ev));
            chk($sformatf("vec%0d.in_ready", i), DATA_W'(in_ready), DATA_W'(vt[i].eir));
            chk($sformatf("vec%0d.out_data", i), out_data, DATA_W'(vt[i].ed));
            chk($sformatf("vec%0d.out_ctrl", i), DATA_W'(out_ctrl), DATA_W'(vt[i].ec));
        end

        // Streaming: 8 back-to-back transfers, one bubble after release plus the first input edge
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, DATA_W'(i), CTRL_W'(i + 1));
            step();
            chk($sformatf("stream%0d.out_valid", i), DATA_W'(out_valid), DATA_W'(1));
            chk($sformatf("stream%0d.out_data", i), out_data, DATA_W'(i));
            chk($sformatf("stream%0d.out_ctrl", i), DATA_W'(out_ctrl), DATA_W'(i + 1));
            chk($sformatf("stream%0d.in_ready", i), DATA_W'(in_ready), DATA_W'(1));
        end
        chk("stream.bubble_cnt", DATA_W'(bubble_cnt), DATA_W'(2));
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        chk("stream.drain_valid", DATA_W'(out_valid), DATA_W'(0));

        // Bubble counter saturation and clear
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        repeat (10) step();
        chk("bub.sat_c", DATA_W'(bubble_cnt_c), DATA_W'(7));
        chk("bub.cnt10", DATA_W'(bubble_cnt), DATA_W'(10));
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
        step();
        chk("bub.clr", DATA_W'(bubble_cnt), DATA_W'(0));
        chk("bub.clr_c", DATA_W'(bubble_cnt_c), DATA_W'(0));
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        step();
        chk("bub.flush_keeps", DATA_W'(bubble_cnt), DATA_W'(1));

        // Reset in TWO, then a fresh transfer with 1-cycle latency
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DATA_W'(8'ha1), CTRL_W'(1));
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, DATA_W'(8'hb2), CTRL_W'(2));
        step();
        chk("rst.two_in_ready", DATA_W'(in_ready), DATA_W'(0));
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, DATA_W'(8'hee), CTRL_W'(3));
        step();
        chk("rst.out_valid", DATA_W'(out_valid), DATA_W'(0));
        chk("rst.out_data", out_data, DATA_W'(0));
        chk("rst.out_ctrl", DATA_W'(out_ctrl), DATA_W'(0));
        chk("rst.in_ready", DATA_W'(in_ready), DATA_W'(0));
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
        step();
        chk("rst.after_in_ready", DATA_W'(in_ready), DATA_W'(1));
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, DATA_W'(8'hc3), CTRL_W'(5));
        step();
        chk("rst.new_valid", DATA_W'(out_valid), DATA_W'(1));
        chk("rst.new_data", out_data, DATA_W'(8'hc3));
        chk("rst.new_ctrl", DATA_W'(out_ctrl), DATA_W'(5));

        // Randomized traffic against the queue model
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        step();
        for (int i = 0; i < 1000; i++) begin
            for (int k = 0; k < 6; k++) rnd[k*32 +: 32] = $urandom();
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 31) == 0),
                  rnd[DATA_W-1:0],
                  CTRL_W'($urandom()));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
